// File: rtl/easy_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | easy_fifo_pkg : shared constants, helpers and types for the FIFO    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package easy_fifo_pkg;

  localparam int C_RD_LAT_MIN     = 1;
  localparam int C_RD_LAT_MAX     = 2;
  localparam int C_MAX_BUF_DEPTH  = C_RD_LAT_MAX + 1;

  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit rd_lat_legal(input int lat);
    return (lat >= C_RD_LAT_MIN) && (lat <= C_RD_LAT_MAX);
  endfunction

  // Wide enough for 0..C_MAX_BUF_DEPTH inclusive.
  typedef logic [$clog2(C_MAX_BUF_DEPTH + 1)-1:0] occ_t;

endpackage
`default_nettype wire

// File: rtl/fwft_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwft_skid_buf : circular DEPTH x DWIDTH store with push/pop/occ      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fwft_skid_buf
  import easy_fifo_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output occ_t              occ
);

  localparam int C_PTR_W = clog2_min1(DEPTH);

  logic [DWIDTH-1:0]  r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_head;
  logic [C_PTR_W-1:0] r_tail;
  occ_t               r_occ;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
    return (p == C_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (push) begin
        r_mem[r_tail] <= push_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (pop) r_head <= ptr_inc(r_head);
      if (push && !pop)      r_occ <= r_occ + 1'b1;
      else if (pop && !push) r_occ <= r_occ - 1'b1;
    end
  end

  assign head_data = r_mem[r_head];
  assign occ       = r_occ;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (r_occ == occ_t'(DEPTH))))
    else $error("fwft_skid_buf: push into full buffer");

endmodule
`default_nettype wire

// File: rtl/async_fwft_out.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | async_fwft_out : registered-read RAM port to FWFT valid/ready stream |
// | Optional: define FWFT_BEAT_CNT_EN for the beat_cnt output counter.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module async_fwft_out
  import easy_fifo_pkg::*;
#(
  parameter int DWIDTH = 64,
  parameter int RD_LAT = 1
) (
  input  logic              rd_clk,
  input  logic              rst,
  input  logic              rd_empty,
  output logic              rd_en,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
`ifdef FWFT_BEAT_CNT_EN
  output logic [31:0]       beat_cnt,
`endif
  input  logic              m_ready
);

  localparam int BUF_DEPTH = RD_LAT + 1;
  localparam int C_PEND_W  = 4;

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("async_fwft_out: RD_LAT must be 1 or 2");
  end

  logic [RD_LAT-1:0]   r_infl;
  logic                w_pop;
  logic                w_push;
  occ_t                w_occ;
  logic [C_PEND_W-1:0] w_pend_after_pop;

  assign w_pop   = m_valid & m_ready;
  assign w_push  = r_infl[RD_LAT-1];
  assign m_valid = (w_occ != '0);

  // Credit: never request more words than the buffer can hold once every
  // in-flight read lands, counting the slot freed by this cycle's pop.
  always_comb begin
    w_pend_after_pop = C_PEND_W'(w_occ) + C_PEND_W'($countones(r_infl)) - C_PEND_W'(w_pop);
    rd_en            = ~rst & ~rd_empty & (w_pend_after_pop < C_PEND_W'(BUF_DEPTH));
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      r_infl <= '0;
    end else begin
      r_infl[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) r_infl[i] <= r_infl[i-1];
    end
  end

  fwft_skid_buf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (BUF_DEPTH)
  ) u_skid (
    .clk       (rd_clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (ram_dout),
    .pop       (w_pop),
    .head_data (m_data),
    .occ       (w_occ)
  );

`ifdef FWFT_BEAT_CNT_EN
  logic [31:0] r_beat_cnt;

  always_ff @(posedge rd_clk) begin
    if (rst)        r_beat_cnt <= '0;
    else if (w_pop) r_beat_cnt <= r_beat_cnt + 32'd1;
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule
`default_nettype wire
